// File: rtl/usb_pll_ctrl_pkg.sv
// usb_pll_ctrl_pkg: shared types and constants for the USB PLL lock controller.
// Holds the FSM state enum, default parameter values and output widths.
package usb_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_READY     = 3'd4,
        ST_FAIL      = 3'd5
    } pll_state_e;

    localparam int DEF_RST_CYCLES    = 20;
    localparam int DEF_STABLE_CYCLES = 2000;
    localparam int DEF_LOCK_TIMEOUT  = 20000;
    localparam int DEF_MAX_RETRY     = 3;

    localparam int RETRY_W = 2;
    localparam int LOSS_W  = 8;
    localparam int STATE_W = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/usb_pll_lock_ctrl_if.sv
// usb_pll_lock_ctrl_if: request/status bundle between a host and the controller.
// slave: controller side (takes enable/pll_locked, drives status); master: host side.
interface usb_pll_lock_ctrl_if;
    import usb_pll_ctrl_pkg::*;

    logic               enable;
    logic               pll_locked;
    logic               pll_rst;
    logic               clk_ready;
    logic               lock_fail;
    logic [RETRY_W-1:0] retry_cnt;
    logic [LOSS_W-1:0]  loss_cnt;
    logic [STATE_W-1:0] state;

    modport master (
        output enable, pll_locked,
        input  pll_rst, clk_ready, lock_fail,
        input  retry_cnt, loss_cnt, state
    );

    modport slave (
        input  enable, pll_locked,
        output pll_rst, clk_ready, lock_fail,
        output retry_cnt, loss_cnt, state
    );

endinterface

// File: rtl/usb_pll_sync2.sv
// usb_pll_sync2: one-bit two-flop synchronizer, async active-low reset.
// Ports: clk, rst_n, i_d (async input), o_q (synchronized output).
module usb_pll_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/usb_pll_lock_ctrl.sv
// usb_pll_lock_ctrl: PLL reset/lock bring-up sequencer for the 60 MHz USB clocks.
// Ports: refclk, rst_n, bus (slave modport). Option: USB_PLL_CTRL_LOSS_CNT_EN.
module usb_pll_lock_ctrl
    import usb_pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input logic               refclk,
    input logic               rst_n,
    usb_pll_lock_ctrl_if.slave bus
);

    localparam int TMR_MAX = max3(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    // Timer holds remaining cycles minus one, so a phase of N cycles
    // ends on the cycle the count reads 0.
    localparam logic [TMR_W-1:0] T_RST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_STB = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_TO  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] R_MAX = RETRY_W'(MAX_RETRY);

    pll_state_e         r_state;
    pll_state_e         w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [RETRY_W-1:0] w_retry_inc;
    logic               r_pll_rst;
    logic               r_clk_ready;
    logic               r_lock_fail;
    logic               w_fail_nxt;
    logic               w_lock;
    logic               w_tmr_zero;

    usb_pll_sync2 u_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .i_d   (bus.pll_locked),
        .o_q   (w_lock)
    );

    assign w_tmr_zero  = (r_timer == '0);
    assign w_retry_inc = r_retry_cnt + RETRY_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry_cnt;
        w_fail_nxt  = r_lock_fail;
        // Dropping enable overrides every other event, including lock loss.
        if (!bus.enable && r_state != ST_IDLE) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        w_state_nxt = ST_RESET;
                        w_timer_nxt = T_RST;
                        w_retry_nxt = '0;
                        w_fail_nxt  = 1'b0;
                    end
                end
                ST_RESET: begin
                    if (w_tmr_zero) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = T_TO;
                    end else begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock) begin
                        w_state_nxt = ST_STABLE;
                        w_timer_nxt = T_STB;
                    end else if (w_tmr_zero) begin
                        w_retry_nxt = w_retry_inc;
                        if (w_retry_inc == R_MAX) begin
                            w_state_nxt = ST_FAIL;
                            w_fail_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_RESET;
                            w_timer_nxt = T_RST;
                        end
                    end else begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!w_lock) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = T_TO;
                    end else if (w_tmr_zero) begin
                        w_state_nxt = ST_READY;
                    end else begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end
                end
                ST_READY: begin
                    if (!w_lock) begin
                        w_state_nxt = ST_RESET;
                        w_timer_nxt = T_RST;
                    end
                end
                ST_FAIL: begin
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they change
    // on the same edge as the state they describe.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_retry_cnt <= '0;
            r_pll_rst   <= 1'b1;
            r_clk_ready <= 1'b0;
            r_lock_fail <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_pll_rst   <= (w_state_nxt == ST_IDLE)
                        || (w_state_nxt == ST_RESET)
                        || (w_state_nxt == ST_FAIL);
            r_clk_ready <= (w_state_nxt == ST_READY);
            r_lock_fail <= w_fail_nxt;
        end
    end

`ifdef USB_PLL_CTRL_LOSS_CNT_EN
    logic [LOSS_W-1:0] r_loss_cnt;
    logic              w_loss_evt;

    assign w_loss_evt = (r_state == ST_READY) && bus.enable && !w_lock;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt && (r_loss_cnt != '1)) begin
            r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
        end
    end

    assign bus.loss_cnt = r_loss_cnt;
`else
    assign bus.loss_cnt = '0;
`endif

    assign bus.pll_rst   = r_pll_rst;
    assign bus.clk_ready = r_clk_ready;
    assign bus.lock_fail = r_lock_fail;
    assign bus.retry_cnt = r_retry_cnt;
    assign bus.state     = r_state;

endmodule
